vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480@60 VGA path.
- Produces h_cnt/v_cnt pixel coordinates plus hsync, vsync and valid.
- Sits directly upstream of the pixel address generator, which maps h_cnt/v_cnt to the sprite/frame ROM address.
- Counters advance only on a pixel-rate clock enable; the whole block runs on the single system clock.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  pixel-rate enable, one clk wide (25 MHz tick from 100 MHz clk)
- h_cnt  out  10  horizontal position, 0..H_TOTAL-1
- v_cnt  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- valid  out  1  high when the current position is in the visible area
- line_start  out  1  one-clk pulse when h_cnt wraps to 0
- frame_start  out  1  one-clk pulse when (h_cnt,v_cnt) wraps to (0,0)

Behaviour:
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). All counter compares are 10-bit unsigned.
- Reset (clk edge with rst=1):
  - h_cnt=0, v_cnt=0
  - hsync=vsync=~SYNC_POL (inactive)
  - valid=1, matching the decode of (0,0)
  - line_start=0, frame_start=0
- rst has priority over pix_en. Asserting reset mid-frame returns to (0,0) at the next edge, with no partial-line pulses.
- On a clk edge with pix_en=1:
  - If h_cnt==H_TOTAL-1: h_cnt=0. Then, if v_cnt==V_TOTAL-1, v_cnt=0; otherwise v_cnt+1.
  - Otherwise h_cnt+1.
- With pix_en=0, all registers hold. line_start and frame_start return to 0 on the next clk edge.
- hsync, vsync and valid are registered from the next-state counter values, so they change on the same edge as h_cnt/v_cnt (zero skew, zero latency relative to the counters).
  - hsync active iff H_DISP+H_FP <= h < H_DISP+H_FP+H_SYNC, i.e. 656..751.
  - vsync active iff V_DISP+V_FP <= v < V_DISP+V_FP+V_SYNC, i.e. 490..491.
  - valid iff h < H_DISP and v < V_DISP.
- line_start goes high for exactly one clk on the edge where h_cnt becomes 0 through wrap.
- frame_start goes high on the same edge only when v_cnt also becomes 0. Neither pulse fires out of reset.
- h_cnt/v_cnt are never clamped. Downstream must treat out-of-visible coordinates as blanking.
- Back-to-back pix_en (pix_en held at 1) is legal: the counters then advance every clk.

Optional Feature:
- Macro: VGA_SYNC_PIPE_EN.
- When defined:
  - hsync, vsync and valid gain one extra register stage, advanced on pix_en only, so they lag h_cnt/v_cnt by one pixel.
  - This aligns them with the one-pixel read latency of the downstream block ROM.
  - On reset the extra stage holds syncs inactive and valid=0.
  - h_cnt, v_cnt, line_start and frame_start are unaffected.
- When undefined: zero-lag behaviour as specified above.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 timing constants, used as the parameter defaults
  - CNT_W=10
  - derived H_TOTAL/V_TOTAL and sync start/end localparams
- One natural sub-module: wrap_counter (width, modulus, enable in, value out, wrap pulse out). It is instantiated twice: the horizontal counter is enabled by pix_en, the vertical counter by pix_en AND the horizontal wrap.

Test Plan:
- Reset, then pix_en every 4th clk -> h_cnt=0, v_cnt=0, hsync=vsync=1, valid=1, no pulses; after 4 pix_en ticks h_cnt=4.
- Run one line -> valid falls at h_cnt=640; hsync low for h_cnt 656..751 (96 ticks); line_start one clk high when h_cnt 799->0; v_cnt increments to 1.
- Run a full frame -> vsync low on lines 490-491 only; valid never high for v_cnt>=480; frame_start exactly once per 800*525=420000 ticks.
- Assert rst at h_cnt=300, v_cnt=200, with pix_en high the same cycle -> next edge (0,0) and no line_start/frame_start pulse.
- pix_en=1 continuously -> counter advances every clk and wraps at 799 without skipping.
- VGA_SYNC_PIPE_EN defined -> hsync first goes active one pix_en tick after h_cnt=656; valid falls when h_cnt=641.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync/valid decode record.
// Build option: VGA_SYNC_PIPE_EN adds one pixel of lag on hsync/vsync/valid.
package vga_timing_pkg;
  localparam int CNT_W = 10;

  localparam int H_DISP_DEF   = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_DISP_DEF   = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam bit SYNC_POL_DEF = 1'b0;

  localparam int H_TOTAL      = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_DISP_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_DISP_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
  } sync_t;
endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with a combinational next value and a wrap strobe
// (high while enabled and sitting on the last count).
module wrap_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             wrap
);
  logic at_max;

  always_comb begin
    at_max     = (value == WIDTH'(MODULUS - 1));
    wrap       = en && at_max;
    value_next = value;
    if (en) value_next = at_max ? '0 : value + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) value <= '0;
    else     value <= value_next;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enabled h/v counters with registered sync/valid.
// Build option: VGA_SYNC_PIPE_EN delays hsync/vsync/valid by one pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP   = H_DISP_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_DISP   = V_DISP_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_DISP + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_next, v_next;
  logic             h_wrap, v_wrap;
  sync_t            stage, stage_d;

  wrap_counter #(.WIDTH(CNT_W), .MODULUS(H_TOT)) u_h_cnt (
    .clk(clk), .rst(rst), .en(pix_en),
    .value(h_cnt), .value_next(h_next), .wrap(h_wrap)
  );

  wrap_counter #(.WIDTH(CNT_W), .MODULUS(V_TOT)) u_v_cnt (
    .clk(clk), .rst(rst), .en(h_wrap),
    .value(v_cnt), .value_next(v_next), .wrap(v_wrap)
  );

  function automatic sync_t decode(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    sync_t d;
    d.hsync = (h >= H_SS && h < H_SE) ? SYNC_POL : ~SYNC_POL;
    d.vsync = (v >= V_SS && v < V_SE) ? SYNC_POL : ~SYNC_POL;
    d.valid = (h < H_VIS) && (v < V_VIS);
    return d;
  endfunction

  // Decoding the next-state counters keeps sync/valid edge-aligned with h_cnt/v_cnt.
  assign stage_d = decode(h_next, v_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      stage       <= decode('0, '0);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      stage       <= stage_d;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  sync_t pipe;

  // Extra pixel of lag to match the downstream ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe.hsync <= ~SYNC_POL;
      pipe.vsync <= ~SYNC_POL;
      pipe.valid <= 1'b0;
    end else if (pix_en) begin
      pipe <= stage;
    end
  end

  assign hsync = pipe.hsync;
  assign vsync = pipe.vsync;
  assign valid = pipe.valid;
`else
  assign hsync = stage.hsync;
  assign vsync = stage.vsync;
  assign valid = stage.valid;
`endif
endmodule
